// File: rtl/dbg_spi_master_pkg.sv
// Shared definitions for the MIPS debug pseudo-SPI initiator.
// Holds the command op encodings, FSM state encodings, the default
// MOSI/CS/MISO widths shared with the Mips debug slave and Top_rtl, and a
// small helper used to size the phase counter.
package dbg_spi_master_pkg;

    localparam int DBG_NB_BITS = 32;
    localparam int DBG_NB_MOSI = 25;
    localparam int DBG_NB_CS   = 4;

    typedef enum logic [1:0] {
        OP_XFER  = 2'd0,
        OP_VALID = 2'd1,
        OP_CONT  = 2'd2,
        OP_NOP   = 2'd3
    } dbg_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_HIGH   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_PULSE  = 3'd4,
        ST_RESP   = 3'd5
    } dbg_state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dbg_phase_timer.sv
// Loadable down-counter used to time every phase of the debug SPI FSM.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload the counter with load_val (takes priority)
//   load_val   : phase length minus one
//   done       : counter has reached zero (last cycle of the phase)
// The counter saturates at zero, so it never wraps.
module dbg_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= '0;
        else if (load)           cnt <= load_val;
        else if (cnt != '0)      cnt <= cnt - W'(1);
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/dbg_spi_master.sv
// Hardware initiator for the MIPS debug pseudo-SPI port.
// Takes one command at a time from a valid/ready stream, plays it out on the
// Mips debug pins (one SCLK pulse per transfer, or one valid/continue pulse)
// and returns the captured MISO word on a valid/ready response stream.
// Ports:
//   i_clk, i_rst                 : clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready      : command handshake (ready only in IDLE)
//   i_cmd_op/i_cmd_cs/i_cmd_mosi : op code, CS pattern, MOSI payload
//   o_rsp_valid/i_rsp_ready      : response handshake
//   o_rsp_data                   : captured MISO (0 for a NOP)
//   o_mosi/o_sclk/o_spi_cs       : registered SPI pins to the Mips
//   o_valid/o_continue           : registered strobe pins to the Mips
//   i_miso                       : MISO from the Mips, same clock domain
module dbg_spi_master
    import dbg_spi_master_pkg::*;
#(
    parameter int NB_BITS    = DBG_NB_BITS,
    parameter int NB_MOSI    = DBG_NB_MOSI,
    parameter int NB_CS      = DBG_NB_CS,
    parameter int SETUP_CYC  = 2,
    parameter int HIGH_CYC   = 2,
    parameter int SAMPLE_CYC = 2,
    parameter int PULSE_CYC  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [1:0]         i_cmd_op,
    input  logic [NB_CS-1:0]   i_cmd_cs,
    input  logic [NB_MOSI-1:0] i_cmd_mosi,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [NB_BITS-1:0] o_rsp_data,
    output logic [NB_MOSI-1:0] o_mosi,
    output logic               o_sclk,
    output logic [NB_CS-1:0]   o_spi_cs,
    output logic               o_valid,
    output logic               o_continue,
    input  logic [NB_BITS-1:0] i_miso
);

    localparam int MAX_CYC = max4(SETUP_CYC, HIGH_CYC, SAMPLE_CYC, PULSE_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    dbg_state_e         state, state_n;
    dbg_op_e            cmd_op, op_q, op_n;
    logic [NB_CS-1:0]   cs_q, cs_n;
    logic [NB_MOSI-1:0] mosi_q, mosi_n;
    logic               accept, capture;
    logic               tmr_load, tmr_done;
    logic [CNT_W-1:0]   tmr_val;

    assign cmd_op      = dbg_op_e'(i_cmd_op);
    assign o_cmd_ready = (state == ST_IDLE);
    assign o_rsp_valid = (state == ST_RESP);

    dbg_phase_timer #(.W(CNT_W)) u_timer (
        .clk      (i_clk),
        .rst_n    (i_rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    accept = 1'b1;
                    case (cmd_op)
                        OP_XFER:          state_n = ST_SETUP;
                        OP_VALID, OP_CONT: state_n = ST_PULSE;
                        default:          state_n = ST_RESP;
                    endcase
                end
            end
            ST_SETUP:  if (tmr_done) state_n = ST_HIGH;
            ST_HIGH:   if (tmr_done) state_n = ST_SAMPLE;
            ST_SAMPLE: if (tmr_done) begin state_n = ST_RESP; capture = 1'b1; end
            ST_PULSE:  if (tmr_done) begin state_n = ST_RESP; capture = 1'b1; end
            ST_RESP:   if (i_rsp_ready) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase

        // Values the latches will hold after this edge; pins are registered
        // from these so they line up with the state they belong to.
        op_n   = accept ? cmd_op     : op_q;
        cs_n   = accept ? i_cmd_cs   : cs_q;
        mosi_n = accept ? i_cmd_mosi : mosi_q;

        // Reload on every state entry with the phase length minus one, so
        // done marks the last cycle of the phase.
        tmr_load = (state_n != state);
        case (state_n)
            ST_SETUP:  tmr_val = CNT_W'(SETUP_CYC - 1);
            ST_HIGH:   tmr_val = CNT_W'(HIGH_CYC - 1);
            ST_SAMPLE: tmr_val = CNT_W'(SAMPLE_CYC - 1);
            ST_PULSE:  tmr_val = CNT_W'(PULSE_CYC - 1);
            default:   tmr_val = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_XFER;
            cs_q       <= '0;
            mosi_q     <= '0;
            o_mosi     <= '0;
            o_sclk     <= 1'b0;
            o_spi_cs   <= '0;
            o_valid    <= 1'b0;
            o_continue <= 1'b0;
            o_rsp_data <= '0;
        end else begin
            state  <= state_n;
            op_q   <= op_n;
            cs_q   <= cs_n;
            mosi_q <= mosi_n;

            o_sclk <= (state_n == ST_HIGH);
            if (state_n inside {ST_SETUP, ST_HIGH, ST_SAMPLE}) begin
                o_spi_cs <= cs_n;
                o_mosi   <= mosi_n;
            end else begin
                o_spi_cs <= '0;
                o_mosi   <= '0;
            end
            o_valid    <= (state_n == ST_PULSE) && (op_n == OP_VALID);
            o_continue <= (state_n == ST_PULSE) && (op_n == OP_CONT);

            if (capture)
                o_rsp_data <= i_miso;
            else if (accept && cmd_op == OP_NOP)
                o_rsp_data <= '0;
        end
    end

endmodule

// File: tb/tb_dbg_spi_master.sv
// Self-checking bench for dbg_spi_master: directed pin-timing checks on a
// default instance, plus 100 random back-to-back transfers on a fast
// instance (all transfer phases one cycle) scored against a slave model.
module tb_dbg_spi_master;
    import dbg_spi_master_pkg::*;

    localparam int S_C = 2, H_C = 2, P_C = 2, PU_C = 2;
    localparam logic [31:0] SALT  = 32'hFF06_7300;
    localparam logic [31:0] TAG_V = 32'hA5A5_0001;
    localparam logic [31:0] TAG_C = 32'h5A5A_0002;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Slave response word: depends on the CS/MOSI seen at the SCLK rise.
    function automatic logic [31:0] slave_word(input logic [3:0] cs, input logic [24:0] mosi);
        return {cs, 3'b000, mosi} ^ SALT;
    endfunction

    // ---------------- default instance ----------------
    logic        cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0;
    logic [1:0]  cmd_op = 0;
    logic [3:0]  cmd_cs = 0, spi_cs;
    logic [24:0] cmd_mosi = 0, mosi;
    logic [31:0] rsp_data, miso = 0;
    logic        sclk, pin_valid, pin_cont;

    dbg_spi_master u_dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
        .i_cmd_cs(cmd_cs), .i_cmd_mosi(cmd_mosi),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
        .o_mosi(mosi), .o_sclk(sclk), .o_spi_cs(spi_cs),
        .o_valid(pin_valid), .o_continue(pin_cont), .i_miso(miso)
    );

    logic sclk_q = 0, val_q = 0, cont_q = 0;
    always @(posedge clk) begin
        sclk_q <= sclk;
        val_q  <= pin_valid;
        cont_q <= pin_cont;
        if (sclk && !sclk_q)           miso <= slave_word(spi_cs, mosi);
        else if (pin_valid && !val_q)  miso <= TAG_V;
        else if (pin_cont && !cont_q)  miso <= TAG_C;
    end

    // ---------------- fast instance ----------------
    logic        f_cmd_valid = 0, f_cmd_ready, f_rsp_valid, f_rsp_ready = 1;
    logic [1:0]  f_cmd_op = 0;
    logic [3:0]  f_cmd_cs = 0, f_spi_cs;
    logic [24:0] f_cmd_mosi = 0, f_mosi;
    logic [31:0] f_rsp_data, f_miso = 0;
    logic        f_sclk, f_pin_valid, f_pin_cont;

    dbg_spi_master #(.SETUP_CYC(1), .HIGH_CYC(1), .SAMPLE_CYC(1)) u_fast (
        .i_clk(clk), .i_rst(rst_n),
        .i_cmd_valid(f_cmd_valid), .o_cmd_ready(f_cmd_ready), .i_cmd_op(f_cmd_op),
        .i_cmd_cs(f_cmd_cs), .i_cmd_mosi(f_cmd_mosi),
        .o_rsp_valid(f_rsp_valid), .i_rsp_ready(f_rsp_ready), .o_rsp_data(f_rsp_data),
        .o_mosi(f_mosi), .o_sclk(f_sclk), .o_spi_cs(f_spi_cs),
        .o_valid(f_pin_valid), .o_continue(f_pin_cont), .i_miso(f_miso)
    );

    logic f_slv_q = 0;
    always @(posedge clk) begin
        f_slv_q <= f_sclk;
        if (f_sclk && !f_slv_q) f_miso <= slave_word(f_spi_cs, f_mosi);
    end

    // Fast-instance scoreboard: in-order data, one SCLK pulse per response,
    // and an accept period of 1+1+1+2 cycles while streaming.
    logic [31:0] exp_q[$];
    int   f_rsp_cnt = 0, f_rises = 0, cyc = 0, last_acc = -1;
    logic f_mon_q = 0;
    bit   b2b = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (f_cmd_valid && f_cmd_ready) begin
            if (b2b && last_acc >= 0) chk("f_b2b_period", cyc - last_acc, 5);
            last_acc <= cyc;
        end
    end

    always @(negedge clk) begin
        f_mon_q <= f_sclk;
        if (f_sclk && !f_mon_q) f_rises <= f_rises + 1;
        if (f_rsp_valid && f_rsp_ready) begin
            chk("f_sclk_pulses", f_rises, 1);
            f_rises <= 0;
            if (exp_q.size() == 0) chk("f_unexpected_rsp", 1, 0);
            else                   chk("f_rsp_data", f_rsp_data, exp_q.pop_front());
            f_rsp_cnt <= f_rsp_cnt + 1;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send(input logic [1:0] op, input logic [3:0] cs, input logic [24:0] m);
        int w = 0;
        cmd_valid = 1; cmd_op = op; cmd_cs = cs; cmd_mosi = m;
        while (!cmd_ready && w < 40) begin @(negedge clk); w++; end
        if (w >= 40) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask

    task automatic f_send(input logic [3:0] cs, input logic [24:0] m);
        int w = 0;
        f_cmd_valid = 1; f_cmd_op = OP_XFER; f_cmd_cs = cs; f_cmd_mosi = m;
        while (!f_cmd_ready && w < 40) begin @(negedge clk); w++; end
        if (w >= 40) chk("f_send_timeout", 0, 1);
        @(posedge clk);
        #1 f_cmd_valid = 0;
    endtask

    task automatic release_rsp();
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
    endtask

    // Checks a valid (is_v) or continue pulse that was just accepted.
    task automatic pulse_check(input bit is_v);
        for (int k = 1; k <= PU_C + 1; k++) begin
            @(negedge clk);
            chk("p_valid", pin_valid, is_v && k <= PU_C);
            chk("p_cont",  pin_cont, !is_v && k <= PU_C);
            chk("p_cs",    spi_cs, 0);
            chk("p_mosi",  mosi, 0);
            chk("p_sclk",  sclk, 0);
            chk("p_rspv",  rsp_valid, k == PU_C + 1);
        end
        chk("p_data", rsp_data, is_v ? TAG_V : TAG_C);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] rm;
        logic [3:0]  rc;

        // reset state
        #2;
        chk("rst_sclk", sclk, 0);
        chk("rst_cs", spi_cs, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);

        // op0 with known payload: pins per cycle after the accept edge
        send(OP_XFER, 4'b0010, 25'h1ABCDEF);
        for (int k = 1; k <= S_C + H_C + P_C + 1; k++) begin
            bit in_x;
            @(negedge clk);
            in_x = (k <= S_C + H_C + P_C);
            chk("x_sclk", sclk, k > S_C && k <= S_C + H_C);
            chk("x_cs",   spi_cs, in_x ? 4'b0010 : 4'b0000);
            chk("x_mosi", mosi, in_x ? 25'h1ABCDEF : 25'h0);
            chk("x_rspv", rsp_valid, !in_x);
            chk("x_ready", cmd_ready, 0);
        end
        chk("x_data", rsp_data, 32'hDEADBEEF);

        // backpressure with a pending op1 command
        cmd_valid = 1; cmd_op = OP_VALID; cmd_cs = 4'hF; cmd_mosi = 25'($urandom);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_ready", cmd_ready, 0);
            chk("bp_rspv", rsp_valid, 1);
            chk("bp_data", rsp_data, 32'hDEADBEEF);
        end
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        @(negedge clk);
        chk("bp_ready_after", cmd_ready, 1);
        chk("bp_rspv_after", rsp_valid, 0);
        @(posedge clk);
        #1 cmd_valid = 0;
        pulse_check(1'b1);
        release_rsp();

        // op2
        send(OP_CONT, 4'hA, 25'($urandom));
        pulse_check(1'b0);
        release_rsp();

        // op3 NOP
        send(OP_NOP, 4'h5, 25'($urandom));
        @(negedge clk);
        chk("nop_rspv", rsp_valid, 1);
        chk("nop_data", rsp_data, 0);
        chk("nop_pins", {sclk, pin_valid, pin_cont, |spi_cs, |mosi}, 0);
        release_rsp();

        // a few random op0 transfers on the default instance
        for (int i = 0; i < 4; i++) begin
            rc = 4'($urandom); rm = 25'($urandom);
            send(OP_XFER, rc, rm);
            repeat (S_C + H_C + P_C + 1) @(negedge clk);
            chk("r_rspv", rsp_valid, 1);
            chk("r_data", rsp_data, slave_word(rc, rm));
            release_rsp();
        end

        // reset during HIGH
        send(OP_XFER, 4'b1000, 25'($urandom));
        repeat (S_C + 1) @(negedge clk);
        chk("mr_sclk_before", sclk, 1);
        #2 rst_n = 0;
        #1;
        chk("mr_sclk", sclk, 0);
        chk("mr_cs", spi_cs, 0);
        chk("mr_mosi", mosi, 0);
        chk("mr_rspv", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mr_ready_after", cmd_ready, 1);
            chk("mr_rspv_after", rsp_valid, 0);
            chk("mr_sclk_after", sclk, 0);
        end

        // fast instance: 100 back-to-back op0 transfers
        b2b = 1;
        for (int i = 0; i < 100; i++) begin
            rc = 4'($urandom); rm = 25'($urandom);
            exp_q.push_back(slave_word(rc, rm));
            f_send(rc, rm);
        end
        for (int w = 0; w < 50 && f_rsp_cnt < 100; w++) @(negedge clk);
        b2b = 0;
        chk("f_rsp_count", f_rsp_cnt, 100);
        chk("f_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
